// File: rtl/parity_frame_ctrl_if.sv
// Word-in / result-out handshake bundle for parity_frame_ctrl.
// The slave modport is the controller's view; master is the upstream/downstream side.
interface parity_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for an external serial parity checker: capture word, clear checker,
// stream bits LSB-first, sample the Mealy output on the last bit, return a pass/fail result.
module parity_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  parity_frame_ctrl_if.slave  bus,
  output logic [7:0]          err_cnt,
  output logic                busy,
  output logic                pc_clr,
  output logic                pc_x,
  input  logic                pc_z
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, RESULT} state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_err_q;
  logic              in_ready;
  logic              out_valid;
  logic              calc_par;

  assign calc_par      = pc_z;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    pc_clr     = 1'b0;
    pc_x       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) next_state = CLR;
      end
      CLR: begin
        pc_clr     = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        pc_x = data_q[cnt];
        if (cnt == LAST) next_state = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers load on the final shift so they hold through IDLE/CLR/SHIFT of the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q     <= '0;
      par_q      <= 1'b0;
      cnt        <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            par_q  <= bus.in_par;
          end
        end
        CLR: cnt <= '0;
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_data_q <= data_q;
            out_err_q  <= calc_par ^ par_q ^ ODD;
          end
        end
        RESULT: begin
          if (bus.out_ready && out_err_q && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
